// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the multi-cycle MIPS control path
// Holds the sequencer state enum, opcode values, aluop / alu_src_b / pc_src
// select encodings, and the DECODE-state opcode dispatch helper.
package mips_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL, S_HALT
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   // aluop encoding shared with the ALU-control decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: decode_next = S_MEMADR;
         OP_RTYPE:     decode_next = S_EXEC;
         OP_BEQ:       decode_next = S_BRANCH;
         OP_ADDI:      decode_next = S_ADDIEX;
         OP_J:         decode_next = S_JUMP;
         default:      decode_next = S_ILLEGAL;
      endcase
   endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational control-output decode for the sequencer
// Inputs: state, mem_ready (FETCH gating), zero (BRANCH gating), rst.
// Outputs: every datapath select and write enable of mc_control.
module mc_ctrl_decode
   import mips_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic       zero,
   input  logic       rst,
   output logic       mem_req,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal_op,
   output logic       halted
);
   state_t s;
   // under reset decode as FETCH with every write/request suppressed
   assign s = rst ? S_FETCH : state;
   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      aluop      = ALU_ADD;
      pc_src     = PC_ALU;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
      halted     = 1'b0;
      case (s)
         S_FETCH: begin
            mem_req   = ~rst;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready & ~rst;
            pc_en     = mem_ready & ~rst;
         end
         S_DECODE:  alu_src_b = SRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            aluop     = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_en     = zero;
         end
         S_ADDIWB:  reg_write = 1'b1;
         S_JUMP: begin
            pc_src = PC_JUMP;
            pc_en  = 1'b1;
         end
         S_ILLEGAL: illegal_op = 1'b1;
         S_HALT:    halted = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control sequencer
// Params: ILLEGAL_TRAP (1 = unknown opcode halts, 0 = pulse and refetch).
// Inputs: clk, rst (async, active-high), opcode, zero, mem_ready.
// Outputs: memory request/select/write, IR/reg/PC enables, mux selects,
// aluop, illegal_op pulse and halted status.
module mc_control
   import mips_pkg::*;
#(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal_op,
   output logic       halted
);
   state_t state, next;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_FETCH;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         S_FETCH:   next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:  next = decode_next(opcode);
         S_MEMADR:  next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:    next = S_ALUWB;
         S_ADDIEX:  next = S_ADDIWB;
         S_ILLEGAL: next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
         S_HALT:    next = S_HALT;
         default:   next = S_FETCH;
      endcase
   end
   mc_ctrl_decode u_dec (
      .state      (state),
      .mem_ready  (mem_ready),
      .zero       (zero),
      .rst        (rst),
      .mem_req    (mem_req),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .aluop      (aluop),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .illegal_op (illegal_op),
      .halted     (halted)
   );
endmodule
